// File: rtl/lfsr_gen.sv
// lfsr_gen: configurable-width Galois/Fibonacci LFSR with multi-step advance,
// runtime seed load, all-zero lockup recovery and period measurement.
module lfsr_gen #(
  parameter int unsigned NBITS = 8,
  parameter logic [31:0] TAPS  = 32'h1D,
  parameter int unsigned MODE  = 0,
  parameter int unsigned STEPS = 1,
  parameter logic [31:0] SEED  = 32'h1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [NBITS-1:0] seed_in,
  output logic [NBITS-1:0] lfsr,
  output logic             wrap,
  output logic             lockup,
  output logic [NBITS-1:0] period
);

  // Tap bits at or above NBITS are dropped here.
  localparam logic [NBITS-1:0] TAP_MASK = TAPS[NBITS-1:0];
  localparam logic [NBITS-1:0] SEED_VAL = SEED[NBITS-1:0];

  logic [NBITS-1:0] seed_q;
  logic [NBITS-1:0] count;
  logic [NBITS-1:0] stepped;
  logic [NBITS-1:0] cnt_inc;

  // One shift of the register in the selected topology.
  function automatic logic [NBITS-1:0] step(input logic [NBITS-1:0] s);
    logic [NBITS-1:0] n;
    if (MODE == 0) begin
      n = {s[NBITS-2:0], 1'b0} ^ (s[NBITS-1] ? TAP_MASK : '0);
    end else begin
      n = {s[NBITS-2:0], ^(s & TAP_MASK)};
    end
    return n;
  endfunction

  // STEPS single steps chained combinationally so an update has no extra latency.
  always_comb begin
    stepped = lfsr;
    for (int unsigned i = 0; i < STEPS; i++) begin
      stepped = step(stepped);
    end
  end

  // Update counter saturates at all-ones rather than rolling over.
  always_comb begin
    cnt_inc = (count == '1) ? count : count + 1'b1;
  end

  // Register state, seed store, period measurement and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr   <= SEED_VAL;
      seed_q <= SEED_VAL;
      count  <= '0;
      period <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else if (load) begin
      lfsr   <= seed_in;
      seed_q <= seed_in;
      count  <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else if (enable) begin
      if (lfsr == '0) begin
        // Recovery state becomes the new reference so the period is measured from it.
        lfsr   <= {{(NBITS-1){1'b0}}, 1'b1};
        seed_q <= {{(NBITS-1){1'b0}}, 1'b1};
        count  <= '0;
        wrap   <= 1'b0;
        lockup <= 1'b1;
      end else begin
        lfsr   <= stepped;
        lockup <= 1'b0;
        if (stepped == seed_q) begin
          wrap   <= 1'b1;
          period <= cnt_inc;
          count  <= '0;
        end else begin
          wrap  <= 1'b0;
          count <= cnt_inc;
        end
      end
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end
  end

endmodule
